// File: rtl/irq_vector_ctrl.sv
// irq_vector_ctrl
//   Vectored interrupt controller with a 16-byte memory-mapped register window.
//   Each channel latches a pending bit on a rising edge (or follows the input
//   when in level mode). The lowest-index pending, unmasked channel wins and
//   its handler address is presented on vector. The CPU commits entry with
//   take and leaves the handler with eret.
//
//   Optional feature macro: IRQ_LEVEL_EN
//     defined   -> MODE register implemented (bit=1 selects level mode)
//     undefined -> every channel is edge mode, MODE reads 0, writes ignored
//
// Register window (byte offsets from ADDR_BASE, addr[1:0] ignored):
//   0x0 PEND   W1C   pending bits
//   0x4 MASK   RW    enable bits
//   0x8 MODE   RW    0 = edge, 1 = level
//   0xC STATUS RO    bit8 in_service, bits3:0 active id
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-high reset
//   irq_in   in   NUM_IRQ interrupt sources, synchronous to clk
//   monin    in   kernel-mode flag, 1 blocks interrupt requests
//   rd, wr   in   bus read / write strobes
//   addr     in   bus byte address
//   wdata    in   bus write data
//   rdata    out  bus read data (combinational)
//   take     in   CPU commits exception entry
//   eret     in   CPU returns from handler
//   irq_req  out  interrupt request (combinational)
//   vector   out  handler address of the winning channel (combinational)

module irq_vector_ctrl #(
  parameter int          NUM_IRQ    = 4,
  parameter logic [31:0] BASE_VEC   = 32'h8000_0008,
  parameter int unsigned VEC_STRIDE = 32'd4,
  parameter logic [31:0] ADDR_BASE  = 32'h4000_0030
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               monin,
  input  logic               rd,
  input  logic               wr,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  input  logic               take,
  input  logic               eret,
  output logic               irq_req,
  output logic [31:0]        vector
);

  logic [NUM_IRQ-1:0] irq_prev_r;
  logic [NUM_IRQ-1:0] pend_r;
  logic [NUM_IRQ-1:0] mask_r;
  logic [NUM_IRQ-1:0] mode_s;
  logic               in_service_r;
  logic [3:0]         id_r;

  logic               win_hit_s;
  logic               rd_hit_s;
  logic [NUM_IRQ-1:0] pend_mask_s;
  logic [NUM_IRQ-1:0] win_oh_s;
  logic [3:0]         winner_s;
  logic               take_fire_s;
  logic [NUM_IRQ-1:0] w1c_s;
  logic [NUM_IRQ-1:0] pend_nxt_s;
  logic               unused_s;

  // Zero-extend a channel-wide register image onto the 32-bit bus.
  function automatic logic [31:0] zext(input logic [NUM_IRQ-1:0] v);
    zext = 32'(v);
  endfunction

  // Only the window base bits take part in decode; low byte lanes are ignored.
  assign win_hit_s   = (addr[31:4] == ADDR_BASE[31:4]);
  assign rd_hit_s    = rd & win_hit_s;
  assign pend_mask_s = pend_r & mask_r;
  assign irq_req     = (|pend_mask_s) & ~monin & ~in_service_r;
  assign take_fire_s = take & irq_req;
  assign vector      = BASE_VEC + (32'(winner_s) * VEC_STRIDE);
  assign unused_s    = &{1'b0, wdata[31:NUM_IRQ], addr[1:0]};

`ifdef IRQ_LEVEL_EN
  logic [NUM_IRQ-1:0] mode_r;

  // MODE register: software-selected edge/level per channel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_r <= '0;
    end else if (wr && win_hit_s && (addr[3:2] == 2'b10)) begin
      mode_r <= wdata[NUM_IRQ-1:0];
    end else begin
      mode_r <= mode_r;
    end
  end

  assign mode_s = mode_r;
`else
  assign mode_s = '0;
`endif

  // Priority pick: scan downward so the lowest pending index is the last hit.
  always_comb begin
    winner_s = 4'd0;
    win_oh_s = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend_mask_s[i]) begin
        winner_s    = 4'(i);
        win_oh_s    = '0;
        win_oh_s[i] = 1'b1;
      end else begin
        winner_s = winner_s;
      end
    end
  end

  // W1C strobe for PEND.
  always_comb begin
    if (wr && win_hit_s && (addr[3:2] == 2'b00)) begin
      w1c_s = wdata[NUM_IRQ-1:0];
    end else begin
      w1c_s = '0;
    end
  end

  // PEND next state: level channels follow the sampled input; edge channels
  // clear on W1C or on take of the winner, and a fresh edge overrides both.
  always_comb begin
    pend_nxt_s = pend_r;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (mode_s[i]) begin
        pend_nxt_s[i] = irq_in[i];
      end else begin
        pend_nxt_s[i] = (irq_in[i] & ~irq_prev_r[i]) |
                        (pend_r[i] & ~w1c_s[i] & ~(take_fire_s & win_oh_s[i]));
      end
    end
  end

  // Input sample, PEND and MASK state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_prev_r <= '0;
      pend_r     <= '0;
      mask_r     <= '0;
    end else begin
      irq_prev_r <= irq_in;
      pend_r     <= pend_nxt_s;
      if (wr && win_hit_s && (addr[3:2] == 2'b01)) begin
        mask_r <= wdata[NUM_IRQ-1:0];
      end else begin
        mask_r <= mask_r;
      end
    end
  end

  // Service tracking: take has priority over a same-cycle eret.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_service_r <= 1'b0;
      id_r         <= 4'd0;
    end else if (take_fire_s) begin
      in_service_r <= 1'b1;
      id_r         <= winner_s;
    end else if (eret) begin
      in_service_r <= 1'b0;
      id_r         <= id_r;
    end else begin
      in_service_r <= in_service_r;
      id_r         <= id_r;
    end
  end

  // Bus read mux.
  always_comb begin
    rdata = 32'd0;
    if (rd_hit_s) begin
      case (addr[3:2])
        2'b00:   rdata = zext(pend_r);
        2'b01:   rdata = zext(mask_r);
        2'b10:   rdata = zext(mode_s);
        2'b11:   rdata = {23'd0, in_service_r, 4'd0, id_r};
        default: rdata = 32'd0;
      endcase
    end else begin
      rdata = 32'd0;
    end
  end

endmodule

// File: tb/tb_irq_vector_ctrl.sv
module tb_irq_vector_ctrl;

  localparam logic [31:0] A_PEND = 32'h4000_0030;
  localparam logic [31:0] A_MASK = 32'h4000_0034;
  localparam logic [31:0] A_MODE = 32'h4000_0038;
  localparam logic [31:0] A_STAT = 32'h4000_003C;
  localparam logic [31:0] V0 = 32'h8000_0008;
  localparam logic [31:0] V1 = 32'h8000_000C;
  localparam logic [31:0] V2 = 32'h8000_0010;
  localparam logic [31:0] V3 = 32'h8000_0014;
`ifdef IRQ_LEVEL_EN
  localparam logic [31:0] MODE_EXP = 32'h0000_000F;
`else
  localparam logic [31:0] MODE_EXP = 32'h0000_0000;
`endif

  logic        clk;
  logic        reset;
  logic [3:0]  irq_in;
  logic        monin;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        take;
  logic        eret;
  logic        irq_req;
  logic [31:0] vector;

  int checks;
  int failures;

  typedef struct {
    logic [3:0]  irq;
    logic        mon;
    logic        rdv;
    logic        wrv;
    logic [31:0] a;
    logic [31:0] wd;
    logic        tk;
    logic        er;
    logic        ereq;
    logic [31:0] evec;
    logic [31:0] erd;
  } vec_t;

  vec_t tbl[41];

  irq_vector_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .irq_in  (irq_in),
    .monin   (monin),
    .rd      (rd),
    .wr      (wr),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .take    (take),
    .eret    (eret),
    .irq_req (irq_req),
    .vector  (vector)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] irq, input logic mon, input logic rdv,
                              input logic wrv, input logic [31:0] a, input logic [31:0] wd,
                              input logic tk, input logic er, input logic ereq,
                              input logic [31:0] evec, input logic [31:0] erd);
    vec_t v;
    v.irq = irq; v.mon = mon; v.rdv = rdv; v.wrv = wrv; v.a = a; v.wd = wd;
    v.tk = tk; v.er = er; v.ereq = ereq; v.evec = evec; v.erd = erd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge, then let logic settle.
  task automatic drive(input logic [3:0] i_irq, input logic i_mon, input logic i_rd,
                       input logic i_wr, input logic [31:0] i_addr, input logic [31:0] i_wd,
                       input logic i_take, input logic i_eret);
    @(negedge clk);
    irq_in = i_irq; monin = i_mon; rd = i_rd; wr = i_wr;
    addr = i_addr; wdata = i_wd; take = i_take; eret = i_eret;
    #2;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    irq_in = 4'h0; monin = 1'b0; rd = 1'b0; wr = 1'b0;
    addr = 32'h0; wdata = 32'h0; take = 1'b0; eret = 1'b0;

    //            irq   mon   rd    wr    addr              wdata         tk    er    req   vec  rdata
    tbl[0]  = mk(4'h0, 1'b0, 1'b1, 1'b0, A_PEND,           32'h0,        1'b0, 1'b0, 1'b0, V0, 32'h0);
    tbl[1]  = mk(4'h0, 1'b0, 1'b0, 1'b1, A_MASK,           32'hF,        1'b0, 1'b0, 1'b0, V0, 32'h0);
    tbl[2]  = mk(4'h0, 1'b0, 1'b1, 1'b0, A_MASK,           32'h0,        1'b0, 1'b0, 1'b0, V0, 32'hF);
    tbl[3]  = mk(4'h4, 1'b0, 1'b1, 1'b0, A_PEND,           32'h0,        1'b0, 1'b0, 1'b0, V0, 32'h0);
    tbl[4]  = mk(4'h4, 1'b0, 1'b1, 1'b0, A_PEND,           32'h0,        1'b0, 1'b0, 1'b1, V2, 32'h4);
    tbl[5]  = mk(4'h0, 1'b0, 1'b1, 1'b0, A_STAT,           32'h0,        1'b1, 1'b0, 1'b1, V2, 32'h0);
    tbl[6]  = mk(4'h0, 1'b0, 1'b1, 1'b0, A_STAT,           32'h0,        1'b0, 1'b0, 1'b0, V0, 32'h102);
    tbl[7]  = mk(4'h0, 1'b0, 1'b1, 1'b0, A_PEND,           32'h0,        1'b0, 1'b1, 1'b0, V0, 32'h0);
    tbl[8]  = mk(4'h0, 1'b0, 1'b1, 1'b0, A_STAT,           32'h0,        1'b0, 1'b0, 1'b0, V0, 32'h002);
    tbl[9]  = mk(4'hA, 1'b0, 1'b1, 1'b0, A_PEND,           32'h0,        1'b0, 1'b0, 1'b0, V0, 32'h0);
    tbl[10] = mk(4'hA, 1'b0, 1'b1, 1'b0, A_PEND,           32'h0,        1'b1, 1'b0, 1'b1, V1, 32'hA);
    tbl[11] = mk(4'hA, 1'b0, 1'b1, 1'b0, A_STAT,           32'h0,        1'b0, 1'b0, 1'b0, V3, 32'h101);
    tbl[12] = mk(4'hA, 1'b0, 1'b1, 1'b0, A_PEND,           32'h0,        1'b0, 1'b1, 1'b0, V3, 32'h8);
    tbl[13] = mk(4'hA, 1'b0, 1'b1, 1'b0, A_PEND,           32'h0,        1'b1, 1'b1, 1'b1, V3, 32'h8);
    tbl[14] = mk(4'h0, 1'b0, 1'b1, 1'b0, A_STAT,           32'h0,        1'b0, 1'b0, 1'b0, V0, 32'h103);
    tbl[15] = mk(4'h0, 1'b0, 1'b1, 1'b0, A_STAT,           32'h0,        1'b0, 1'b1, 1'b0, V0, 32'h103);
    tbl[16] = mk(4'h0, 1'b0, 1'b1, 1'b0, A_STAT,           32'h0,        1'b1, 1'b0, 1'b0, V0, 32'h003);
    tbl[17] = mk(4'h0, 1'b0, 1'b1, 1'b0, A_STAT,           32'h0,        1'b0, 1'b0, 1'b0, V0, 32'h003);
    tbl[18] = mk(4'h1, 1'b1, 1'b1, 1'b0, A_PEND,           32'h0,        1'b0, 1'b0, 1'b0, V0, 32'h0);
    tbl[19] = mk(4'h1, 1'b1, 1'b1, 1'b0, A_PEND,           32'h0,        1'b0, 1'b0, 1'b0, V0, 32'h1);
    tbl[20] = mk(4'h1, 1'b0, 1'b1, 1'b0, A_PEND,           32'h0,        1'b0, 1'b0, 1'b1, V0, 32'h1);
    tbl[21] = mk(4'h1, 1'b0, 1'b0, 1'b1, A_MASK,           32'h0,        1'b0, 1'b0, 1'b1, V0, 32'h0);
    tbl[22] = mk(4'h1, 1'b0, 1'b1, 1'b0, A_MASK,           32'h0,        1'b0, 1'b0, 1'b0, V0, 32'h0);
    tbl[23] = mk(4'h1, 1'b0, 1'b0, 1'b1, A_MASK,           32'hF,        1'b0, 1'b0, 1'b0, V0, 32'h0);
    tbl[24] = mk(4'h1, 1'b0, 1'b0, 1'b1, A_PEND,           32'h1,        1'b0, 1'b0, 1'b1, V0, 32'h0);
    tbl[25] = mk(4'h1, 1'b0, 1'b1, 1'b0, A_PEND,           32'h0,        1'b0, 1'b0, 1'b0, V0, 32'h0);
    tbl[26] = mk(4'h4, 1'b0, 1'b1, 1'b0, A_PEND,           32'h0,        1'b0, 1'b0, 1'b0, V0, 32'h0);
    tbl[27] = mk(4'h0, 1'b0, 1'b1, 1'b0, A_PEND,           32'h0,        1'b0, 1'b0, 1'b1, V2, 32'h4);
    tbl[28] = mk(4'h4, 1'b0, 1'b0, 1'b1, A_PEND,           32'h4,        1'b0, 1'b0, 1'b1, V2, 32'h0);
    tbl[29] = mk(4'h4, 1'b0, 1'b1, 1'b0, A_PEND,           32'h0,        1'b0, 1'b0, 1'b1, V2, 32'h4);
    tbl[30] = mk(4'h4, 1'b0, 1'b0, 1'b1, A_PEND,           32'h4,        1'b0, 1'b0, 1'b1, V2, 32'h0);
    tbl[31] = mk(4'h0, 1'b0, 1'b1, 1'b0, A_PEND,           32'h0,        1'b0, 1'b0, 1'b0, V0, 32'h0);
    tbl[32] = mk(4'h0, 1'b0, 1'b0, 1'b1, A_STAT,           32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, V0, 32'h0);
    tbl[33] = mk(4'h0, 1'b0, 1'b1, 1'b0, A_STAT,           32'h0,        1'b0, 1'b0, 1'b0, V0, 32'h003);
    tbl[34] = mk(4'h0, 1'b0, 1'b0, 1'b1, A_MASK,           32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, V0, 32'h0);
    tbl[35] = mk(4'h0, 1'b0, 1'b1, 1'b0, 32'h4000_0035,    32'h0,        1'b0, 1'b0, 1'b0, V0, 32'hF);
    tbl[36] = mk(4'h0, 1'b0, 1'b0, 1'b1, A_MODE,           32'hF,        1'b0, 1'b0, 1'b0, V0, 32'h0);
    tbl[37] = mk(4'h0, 1'b0, 1'b1, 1'b0, A_MODE,           32'h0,        1'b0, 1'b0, 1'b0, V0, MODE_EXP);
    tbl[38] = mk(4'h0, 1'b0, 1'b0, 1'b1, A_MODE,           32'h0,        1'b0, 1'b0, 1'b0, V0, 32'h0);
    tbl[39] = mk(4'h0, 1'b0, 1'b1, 1'b0, 32'h4000_0040,    32'h0,        1'b0, 1'b0, 1'b0, V0, 32'h0);
    tbl[40] = mk(4'h0, 1'b0, 1'b1, 1'b0, 32'h5000_0030,    32'h0,        1'b0, 1'b0, 1'b0, V0, 32'h0);

    // Reset state while reset is held.
    repeat (2) @(negedge clk);
    rd = 1'b1;
    foreach (tbl[0].a[k]) begin end
    addr = A_PEND; #1; chk("rst_pend", rdata, 32'h0);
    addr = A_MASK; #1; chk("rst_mask", rdata, 32'h0);
    addr = A_STAT; #1; chk("rst_stat", rdata, 32'h0);
    chk("rst_irq_req", {31'd0, irq_req}, 32'h0);
    chk("rst_vector", vector, V0);
    rd = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 41; i++) begin
      drive(tbl[i].irq, tbl[i].mon, tbl[i].rdv, tbl[i].wrv, tbl[i].a, tbl[i].wd,
            tbl[i].tk, tbl[i].er);
      chk($sformatf("row%0d_irq_req", i), {31'd0, irq_req}, {31'd0, tbl[i].ereq});
      chk($sformatf("row%0d_vector", i), vector, tbl[i].evec);
      chk($sformatf("row%0d_rdata", i), rdata, tbl[i].erd);
    end

    // Reset asserted mid-service.
    drive(4'h2, 1'b0, 1'b0, 1'b0, A_PEND, 32'h0, 1'b0, 1'b0);
    drive(4'h0, 1'b0, 1'b0, 1'b0, A_PEND, 32'h0, 1'b1, 1'b0);
    chk("svc_irq_req", {31'd0, irq_req}, 32'h1);
    chk("svc_vector", vector, V1);
    drive(4'h0, 1'b0, 1'b1, 1'b0, A_STAT, 32'h0, 1'b0, 1'b0);
    chk("svc_status", rdata, 32'h101);
    #1 reset = 1'b1;
    #1;
    addr = A_PEND; #1; chk("midrst_pend", rdata, 32'h0);
    addr = A_MASK; #1; chk("midrst_mask", rdata, 32'h0);
    addr = A_MODE; #1; chk("midrst_mode", rdata, 32'h0);
    addr = A_STAT; #1; chk("midrst_stat", rdata, 32'h0);
    chk("midrst_irq_req", {31'd0, irq_req}, 32'h0);
    chk("midrst_vector", vector, V0);
    @(negedge clk);
    reset = 1'b0;
    drive(4'h0, 1'b0, 1'b1, 1'b0, A_STAT, 32'h0, 1'b0, 1'b0);
    chk("postrst_stat", rdata, 32'h0);
    chk("postrst_irq_req", {31'd0, irq_req}, 32'h0);
    chk("postrst_vector", vector, V0);
    drive(4'h0, 1'b0, 1'b1, 1'b0, A_MASK, 32'h0, 1'b0, 1'b0);
    chk("postrst_mask", rdata, 32'h0);

`ifdef IRQ_LEVEL_EN
    // Level channel 0 held high through take and eret.
    drive(4'h0, 1'b0, 1'b0, 1'b1, A_MASK, 32'hF, 1'b0, 1'b0);
    drive(4'h0, 1'b0, 1'b0, 1'b1, A_MODE, 32'h1, 1'b0, 1'b0);
    drive(4'h1, 1'b0, 1'b0, 1'b0, A_PEND, 32'h0, 1'b0, 1'b0);
    chk("lvl_pre_req", {31'd0, irq_req}, 32'h0);
    drive(4'h1, 1'b0, 1'b0, 1'b0, A_PEND, 32'h0, 1'b1, 1'b0);
    chk("lvl_req", {31'd0, irq_req}, 32'h1);
    drive(4'h1, 1'b0, 1'b1, 1'b0, A_PEND, 32'h0, 1'b0, 1'b1);
    chk("lvl_svc_req", {31'd0, irq_req}, 32'h0);
    chk("lvl_svc_pend", rdata, 32'h1);
    drive(4'h0, 1'b0, 1'b1, 1'b0, A_PEND, 32'h0, 1'b0, 1'b0);
    chk("lvl_reassert", {31'd0, irq_req}, 32'h1);
    chk("lvl_pend_held", rdata, 32'h1);
    drive(4'h0, 1'b0, 1'b1, 1'b0, A_PEND, 32'h0, 1'b0, 1'b0);
    chk("lvl_pend_drop", rdata, 32'h0);
    chk("lvl_req_drop", {31'd0, irq_req}, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_vector_ctrl.md
IRQ_VECTOR_CTRL -- requirements
Module: irq_vector_ctrl

Interface
REQ-001 Parameter NUM_IRQ, default 4, meaning number of interrupt channels; legal range 1..16.
REQ-002 Parameter BASE_VEC, default 32'h8000_0008, meaning handler address of channel 0.
REQ-003 Parameter VEC_STRIDE, default 4, meaning byte distance between consecutive channel vectors.
REQ-004 Parameter ADDR_BASE, default 32'h4000_0030, meaning base of the 16-byte register window.
REQ-005 clk  in  1  single system clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 irq_in  in  NUM_IRQ  interrupt sources, synchronous to clk.
REQ-008 monin  in  1  kernel-mode flag (PC[31]); 1 blocks interrupt requests.
REQ-009 rd, wr  in  1 each  bus read and write strobes.
REQ-010 addr  in  32  bus byte address.
REQ-011 wdata  in  32  bus write data.
REQ-012 rdata  out  32  bus read data, combinational.
REQ-013 take  in  1  CPU commits the exception entry this cycle.
REQ-014 eret  in  1  CPU returns from the handler this cycle.
REQ-015 irq_req  out  1  interrupt request to the control unit.
REQ-016 vector  out  32  handler address for the winning channel.

Function
REQ-017 Register map at ADDR_BASE offsets: 0x0 PEND (W1C), 0x4 MASK (RW), 0x8 MODE (RW), 0xC STATUS (RO: bit8 in_service, bits3:0 active id); bits at or above NUM_IRQ read 0 and ignore writes.
REQ-018 rdata equals the addressed register when rd=1 and addr[31:4]==ADDR_BASE[31:4]; otherwise 0; addr[1:0] ignored.
REQ-019 Edge channels (MODE bit 0): the PEND bit sets at the clk edge where irq_in=1 and the previous sample was 0.
REQ-020 Level channels (MODE bit 1): the PEND bit equals irq_in registered once; W1C has no lasting effect.
REQ-021 A set and a W1C on the same PEND bit in the same cycle: set wins.
REQ-022 Winner is the lowest-index bit of PEND&MASK; irq_req = |(PEND&MASK) & ~monin & ~in_service, combinational.
REQ-023 vector = BASE_VEC + winner*VEC_STRIDE, combinational; equals BASE_VEC when nothing is pending.
REQ-024 On take=1 with irq_req=1: in_service<=1, id<=winner, and the winner's PEND bit clears if the channel is edge mode.
REQ-025 take=1 with irq_req=0 has no effect.
REQ-026 eret=1 clears in_service and leaves id unchanged; eret with in_service=0 has no effect.
REQ-027 take and eret in the same cycle: eret is ignored and take is processed.
REQ-028 Latency: an edge sampled at clock edge N raises irq_req in the cycle after edge N, provided it is masked-in and the CPU is not in kernel mode.
REQ-029 Writes to STATUS are ignored; MASK changes take effect on irq_req in the cycle after the write.

Reset
REQ-030 Reset forces to 0: PEND, MASK, MODE, in_service, id and the input sample register; irq_req=0, vector=BASE_VEC, rdata=0.
REQ-031 Reset asserted mid-service discards the in-flight interrupt with no residual state after release.

Configuration
REQ-032 Macro IRQ_LEVEL_EN: when defined, MODE is implemented per REQ-020.
REQ-033 Without IRQ_LEVEL_EN: every channel is edge mode, MODE reads 0, and MODE writes are ignored.

Verification
REQ-034 MASK=0xF; irq_in[2] pulses 0->1 -> PEND=0x4 and irq_req=1 in the next cycle; vector=32'h8000_0010.
REQ-035 irq_in[1] and irq_in[3] rise together; take -> STATUS=0x101, PEND=0x8, irq_req=0; eret -> irq_req=1, vector=32'h8000_0014.
REQ-036 monin=1 with PEND&MASK=0x1 -> irq_req=0; monin falls to 0 -> irq_req=1 in the same cycle.
REQ-037 W1C of 0x4 in the same cycle as a new irq_in[2] edge -> PEND bit 2 remains 1.
REQ-038 IRQ_LEVEL_EN defined, MODE=0x1: irq_in[0] held high through take and eret -> irq_req reasserts after eret; drop irq_in[0] -> PEND[0]=0 one cycle later.
REQ-039 Reset pulse while in_service=1, MASK=0xF -> all registers read 0, irq_req=0, vector=32'h8000_0008.
